// File: rtl/sdff_pipe_pkg.sv
// Shared definitions for the sdff_pipe register pipeline cell.
// Priority modes and scan-chain index mapping.
package sdff_pipe_pkg;

  typedef enum logic [2:0] {
    MODE_RESET,
    MODE_SET,
    MODE_SHIFT,
    MODE_LOAD,
    MODE_HOLD
  } mode_t;

  function automatic int unsigned chain_idx(
    input int unsigned stage,
    input int unsigned bitn,
    input int unsigned width
  );
    return stage * width + bitn;
  endfunction

  function automatic mode_t mode_of(
    input logic r,
    input logic s,
    input logic se,
    input logic e,
    input bit   scan
  );
    mode_t m;
    m = MODE_HOLD;
    unique case (1'b1)
      r:                                  m = MODE_RESET;
      (!r && s):                          m = MODE_SET;
      (!r && !s && se && scan):           m = MODE_SHIFT;
      (!r && !s && !(se && scan) && e):   m = MODE_LOAD;
      default:                            m = MODE_HOLD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sdffrs_bit.sv
// Single flop with sync reset/set, optional scan mux and enable.
// Ternary chain keeps agreeing bits known when a control is X.
module sdffrs_bit #(
  parameter logic RV   = 1'b0,
  parameter logic SV   = 1'b1,
  parameter bit   SCAN = 1'b1
) (
  input  logic ck,
  input  logic r,
  input  logic s,
  input  logic e,
  input  logic se,
  input  logic si,
  input  logic d,
  output logic q
);

  logic fn;
  logic nxt;

  assign fn = e ? d : q;

  if (SCAN) begin : g_scan
    assign nxt = r  ? RV :
                 s  ? SV :
                 se ? si : fn;
  end else begin : g_noscan
    logic unused_scan;
    assign unused_scan = se ^ si;
    assign nxt = r ? RV :
                 s ? SV : fn;
  end

  always_ff @(posedge ck) begin
    q <= nxt;
  end

endmodule

// File: rtl/sdff_pipe.sv
// WIDTH x STAGES register pipeline with sync R/S, enable and scan.
// Chain runs SI -> stage0 bit0 .. last stage MSB -> SO.
module sdff_pipe
  import sdff_pipe_pkg::*;
#(
  parameter int             WIDTH     = 8,
  parameter int             STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL   = '1,
  parameter bit             SCAN      = 1'b1
) (
  input  logic             CK,
  input  logic             R,
  input  logic             S,
  input  logic             E,
  input  logic             SE,
  input  logic             SI,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SO
);

  localparam int N = WIDTH * STAGES;

  logic [N-1:0] st;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      localparam int I = int'(chain_idx(k, b, WIDTH));
      logic dn;
      logic sn;

      if (k == 0) begin : g_din
        assign dn = D[b];
      end else begin : g_dpipe
        assign dn = st[int'(chain_idx(k - 1, b, WIDTH))];
      end

      if (I == 0) begin : g_sin
        assign sn = SI;
      end else begin : g_schain
        assign sn = st[I-1];
      end

      sdffrs_bit #(
        .RV   (RESET_VAL[b]),
        .SV   (SET_VAL[b]),
        .SCAN (SCAN)
      ) u_bit (
        .ck (CK),
        .r  (R),
        .s  (S),
        .e  (E),
        .se (SE),
        .si (sn),
        .d  (dn),
        .q  (st[I])
      );
    end
  end

  assign Q  = st[N-1 -: WIDTH];
  assign QN = ~Q;

  if (SCAN) begin : g_so
    assign SO = st[N-1];
  end else begin : g_so0
    assign SO = 1'b0;
  end

endmodule

// File: tb/tb_sdff_pipe.sv
// Self-checking bench for sdff_pipe (8x2, scan and no-scan builds).
// Reference model tracks stages as bytes and the chain as a 16-bit word.
module tb_sdff_pipe;
  import sdff_pipe_pkg::*;

  logic       CK = 1'b0;
  logic       R = 1'b0, S = 1'b0, E = 1'b0, SE = 1'b0, SI = 1'b0;
  logic [7:0] D = 8'h00;
  logic [7:0] Q, QN, Q0, QN0;
  logic       SO, SO0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ms0, ms1;

  always #5 CK = ~CK;

  sdff_pipe #(.WIDTH(8), .STAGES(2), .SCAN(1'b1)) dut (
    .CK(CK), .R(R), .S(S), .E(E), .SE(SE), .SI(SI), .D(D),
    .Q(Q), .QN(QN), .SO(SO)
  );

  sdff_pipe #(.WIDTH(8), .STAGES(2), .SCAN(1'b0)) dut0 (
    .CK(CK), .R(R), .S(S), .E(E), .SE(SE), .SI(SI), .D(D),
    .Q(Q0), .QN(QN0), .SO(SO0)
  );

  task automatic model_step(input logic r, s, e, se, si,
                            input logic [7:0] d);
    logic [15:0] ch;
    case (mode_of(r, s, se, e, 1'b1))
      MODE_RESET: begin ms0 = 8'h00; ms1 = 8'h00; end
      MODE_SET:   begin ms0 = 8'hFF; ms1 = 8'hFF; end
      MODE_SHIFT: begin
        ch = {ms1, ms0};
        ch = {ch[14:0], si};
        ms1 = ch[15:8];
        ms0 = ch[7:0];
      end
      MODE_LOAD:  begin ms1 = ms0; ms0 = d; end
      default: ;
    endcase
  endtask

  task automatic tick(input logic r, s, e, se, si,
                      input logic [7:0] d);
    R = r; S = s; E = e; SE = se; SI = si; D = d;
    @(posedge CK);
    model_step(r, s, e, se, si, d);
    #1;
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0, 0, 8'h5A);
    n_cmp++;
    if ({Q, QN, SO} !== {8'h00, 8'hFF, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: Q=%h QN=%h SO=%b want 00 ff 0", Q, QN, SO);
    end
    tick(0, 1, 1, 1, 0, 8'h00);
    n_cmp++;
    if ({Q, QN, SO} !== {8'hFF, 8'h00, 1'b1}) begin
      n_bad++;
      $display("FAIL set: Q=%h QN=%h SO=%b want ff 00 1", Q, QN, SO);
    end
    tick(1, 1, 1, 1, 1, 8'hFF);
    n_cmp++;
    if (Q !== 8'h00) begin
      n_bad++;
      $display("FAIL r_wins: Q=%h want 00", Q);
    end
  endtask

  task automatic test_load;
    tick(1, 0, 0, 0, 0, 8'h00);
    tick(0, 0, 1, 0, 0, 8'hA5);
    tick(0, 0, 1, 0, 0, 8'h3C);
    n_cmp++;
    if (Q !== 8'hA5) begin
      n_bad++;
      $display("FAIL load_lat: Q=%h want a5", Q);
    end
    tick(0, 0, 1, 0, 0, 8'h7E);
    n_cmp++;
    if (Q !== 8'h3C) begin
      n_bad++;
      $display("FAIL load_seq: Q=%h want 3c", Q);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 1'($urandom), 8'($urandom));
      n_cmp++;
      if ({Q, QN} !== {8'h3C, 8'hC3}) begin
        n_bad++;
        $display("FAIL hold%0d: Q=%h QN=%h want 3c c3", i, Q, QN);
      end
    end
    tick(0, 0, 1, 0, 0, 8'($urandom));
    n_cmp++;
    if (Q !== 8'h7E) begin
      n_bad++;
      $display("FAIL resume: Q=%h want 7e", Q);
    end
  endtask

  task automatic test_scan_stream;
    logic seq [20];
    logic exp;
    for (int i = 0; i < 20; i++) seq[i] = 1'b0;
    seq[0] = 1'b1; seq[2] = 1'b1; seq[3] = 1'b1;
    tick(1, 0, 0, 0, 0, 8'h00);
    for (int n = 1; n <= 20; n++) begin
      tick(0, 0, 1, 1, seq[n-1], 8'($urandom));
      exp = (n >= 16) ? seq[n-16] : 1'b0;
      n_cmp++;
      if (SO !== exp || Q !== ms1) begin
        n_bad++;
        $display("FAIL scan_edge%0d: SO=%b Q=%h want %b %h",
                 n, SO, Q, exp, ms1);
      end
    end
  endtask

  task automatic test_scan_capture;
    logic [15:0] v;
    v = 16'hBEEF;
    tick(1, 0, 0, 0, 0, 8'h00);
    for (int i = 15; i >= 0; i--) tick(0, 0, 0, 1, v[i], 8'($urandom));
    n_cmp++;
    if ({Q, SO} !== {8'hBE, 1'b1} || ms1 !== 8'hBE) begin
      n_bad++;
      $display("FAIL scan_cap: Q=%h SO=%b want be 1", Q, SO);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 1'($urandom), 8'($urandom));
      n_cmp++;
      if (Q !== 8'hBE) begin
        n_bad++;
        $display("FAIL cap_hold%0d: Q=%h want be", i, Q);
      end
    end
    tick(0, 0, 1, 0, 0, 8'h11);
    n_cmp++;
    if (Q !== 8'hEF) begin
      n_bad++;
      $display("FAIL cap_adv: Q=%h want ef", Q);
    end
  endtask

  task automatic test_reset_midscan;
    logic [15:0] v;
    tick(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) tick(0, 0, 1, 1, 1'b1, 8'hFF);
    tick(1, 0, 1, 1, 1'b1, 8'hFF);
    n_cmp++;
    if ({Q, SO} !== {8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL r_midscan: Q=%h SO=%b want 00 0", Q, SO);
    end
    v = 16'($urandom);
    for (int i = 15; i >= 0; i--) begin
      tick(0, 0, 0, 1, v[i], 8'($urandom));
      n_cmp++;
      if ({Q, QN, SO} !== {ms1, ~ms1, ms1[7]}) begin
        n_bad++;
        $display("FAIL rescan%0d: Q=%h SO=%b want %h %b",
                 i, Q, SO, ms1, ms1[7]);
      end
    end
    n_cmp++;
    if (Q !== v[15:8]) begin
      n_bad++;
      $display("FAIL rescan_end: Q=%h want %h", Q, v[15:8]);
    end
  endtask

  task automatic test_se_drop;
    tick(0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 1'($urandom), 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0, 1'($urandom), 8'($urandom));
      n_cmp++;
      if ({Q, SO} !== {ms1, ms1[7]}) begin
        n_bad++;
        $display("FAIL se_drop%0d: Q=%h want %h", i, Q, ms1);
      end
    end
  endtask

  task automatic test_random;
    logic r, s, e, se;
    tick(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 19) == 0);
      s  = ($urandom_range(0, 19) == 0);
      se = ($urandom_range(0, 3) == 0);
      e  = 1'($urandom);
      tick(r, s, e, se, 1'($urandom), 8'($urandom));
      n_cmp++;
      if ({Q, QN, SO} !== {ms1, ~ms1, ms1[7]}) begin
        n_bad++;
        $display("FAIL rand%0d: Q=%h QN=%h SO=%b want %h %h %b",
                 i, Q, QN, SO, ms1, ~ms1, ms1[7]);
      end
    end
  endtask

  task automatic test_scan0;
    tick(1, 0, 0, 0, 0, 8'h00);
    n_cmp++;
    if ({Q0, SO0} !== {8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL ns_reset: Q=%h SO=%b want 00 0", Q0, SO0);
    end
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 1, 1, 1, 8'h55);
      n_cmp++;
      if (SO0 !== 1'b0) begin
        n_bad++;
        $display("FAIL ns_so%0d: SO=%b want 0", i, SO0);
      end
    end
    n_cmp++;
    if ({Q0, QN0} !== {8'h55, 8'hAA}) begin
      n_bad++;
      $display("FAIL ns_cap: Q=%h QN=%h want 55 aa", Q0, QN0);
    end
  endtask

  initial begin
    ms0 = 8'h00;
    ms1 = 8'h00;
    test_reset;
    test_load;
    test_scan_stream;
    test_scan_capture;
    test_reset_midscan;
    test_se_drop;
    test_random;
    test_scan0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
